// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, 8N1 framing constants and
// the baud divider helper used by both the tx and rx paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered occupancy count and
// combinational read data at the head of the queue.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr;
  logic             rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr      = wr_en && !full;
  assign rd      = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a byte FIFO; frames are sent
// LSB first with registered tx and done outputs.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_tx,
  input  logic       send_tx,
  output logic       ready_tx,
  output logic       tx,
  output logic       busy_tx,
  output logic       done_tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    fifo_data;
  logic          full;
  logic          empty;
  logic          pop;
  logic          phase_end;
  logic          tx_nx;
  logic          done_nx;

  assign ready_tx  = !full;
  assign pop       = (state == IDLE) && !empty;
  assign phase_end = (baud_cnt == LAST);
  assign busy_tx   = (state != IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (send_tx),
    .wr_data (data_tx),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || phase_end || state == IDLE)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + CW'(1);
      if (state != DATA)
        bit_idx <= '0;
      else if (phase_end)
        bit_idx <= bit_idx + 3'd1;
      if (pop)
        shreg <= fifo_data;
      else if (state == DATA && phase_end)
        shreg <= {1'b0, shreg[7:1]};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!empty) state_nx = START;
      START: if (phase_end) state_nx = DATA;
      DATA:  if (phase_end && bit_idx == LAST_BIT) state_nx = STOP;
      STOP:  if (phase_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_nx   = STOP_LVL;
    done_nx = 1'b0;
    unique case (state)
      IDLE:  tx_nx = STOP_LVL;
      START: tx_nx = START_LVL;
      DATA:  tx_nx = shreg[0];
      STOP: begin
        tx_nx   = STOP_LVL;
        done_nx = phase_end;
      end
      default: tx_nx = STOP_LVL;
    endcase
  end

  // Line outputs are registered so tx never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= STOP_LVL;
      done_tx <= 1'b0;
    end else begin
      tx      <= tx_nx;
      done_tx <= done_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level model,
// line decoder and directed scenarios.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 40;
  localparam int BAUD     = 10;
  localparam int DEPTH    = 16;
  localparam int CPB      = 4;
  localparam int FRAME    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send_tx = 1'b0;
  logic [7:0] data_tx = 8'h00;
  logic       ready_tx;
  logic       tx;
  logic       busy_tx;
  logic       done_tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_tx  (data_tx),
    .send_tx  (send_tx),
    .ready_tx (ready_tx),
    .tx       (tx),
    .busy_tx  (busy_tx),
    .done_tx  (done_tx)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a queue of bytes plus the edge of the last pop.
  logic [7:0] mq [$];
  logic [7:0] cur = 8'h00;
  int rem = 0;
  int pop_edge = -1000;
  int edge_n = 0;
  int m_accepted = 0;
  bit do_pop;
  bit do_wr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      rem = 0;
      pop_edge = -1000;
      edge_n = 0;
    end else begin
      edge_n++;
      do_pop = (rem == 0) && (mq.size() > 0);
      do_wr  = send_tx && (mq.size() < DEPTH);
      if (rem > 0) rem--;
      if (do_pop) begin
        cur = mq.pop_front();
        rem = FRAME;
        pop_edge = edge_n;
      end
      if (do_wr) begin
        mq.push_back(data_tx);
        m_accepted++;
      end
    end
  end

  function automatic logic exp_tx();
    int j;
    int b;
    j = edge_n - pop_edge - 1;
    if (j < 0 || j >= FRAME) return 1'b1;
    b = j / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("tx", tx, exp_tx());
      check("busy", busy_tx, rem > 0);
      check("done", done_tx, edge_n == pop_edge + FRAME);
      check("ready", ready_tx, mq.size() < DEPTH);
    end
  end

  // Line monitors: done pulses, low-run lengths, and a UART decoder.
  int done_cnt = 0;
  int run_len = 0;
  int runs [$];
  logic [7:0] rxq [$];
  logic [7:0] rx_byte = 8'h00;
  bit rx_act = 1'b0;
  int rx_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
      run_len = 0;
    end else begin
      if (done_tx) done_cnt++;
      if (tx == 1'b0) run_len++;
      else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
      if (!rx_act) begin
        if (tx == 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % CPB) == 2)
          rx_byte[(rx_cnt-6)/CPB] = tx;
        if (rx_cnt == 38) begin
          check("rx_stop", tx, 1'b1);
          rxq.push_back(rx_byte);
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    @(posedge clk); #1;
    data_tx = b;
    send_tx = 1'b1;
    @(posedge clk); #1;
    send_tx = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy_tx || mq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, n < budget, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  logic [9:0] a5_frame = 10'b1_10100101_0;
  logic       exp_bit;
  logic [7:0] exp_q [$];
  int         d0;
  int         acc0;
  int         waited;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy_tx, 1'b0);
    check("rst_done", done_tx, 1'b0);
    check("rst_ready", ready_tx, 1'b1);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Single 0xA5 frame traced against a hand-written waveform.
    d0 = done_cnt;
    rxq.delete();
    write_byte(8'hA5);
    for (int k = 0; k <= 42; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 42) exp_bit = a5_frame[(k-2)/CPB];
      else exp_bit = 1'b1;
      check("a5_tx", tx, exp_bit);
      check("a5_done", done_tx, k == 41);
    end
    check("a5_busy_after", busy_tx, 1'b0);
    check("a5_done_cnt", done_cnt - d0, 1);
    check("a5_rx_n", rxq.size(), 1);
    if (rxq.size() == 1) check("a5_rx", rxq[0], 8'hA5);

    // Burst 0x01..0x12, then hold 0x7E until space opens.
    d0 = done_cnt;
    acc0 = m_accepted;
    rxq.delete();
    @(posedge clk); #1;
    data_tx = 8'h01;
    send_tx = 1'b1;
    for (int i = 2; i <= 18; i++) begin
      @(posedge clk); #1;
      data_tx = 8'(i);
    end
    @(posedge clk); #1;
    data_tx = 8'h7E;
    check("burst_ready_low", ready_tx, 1'b0);
    check("burst_accepted17", m_accepted - acc0, 17);
    waited = 0;
    while (waited < 100) begin
      @(negedge clk);
      waited++;
      if (ready_tx) begin
        @(posedge clk); #1;
        send_tx = 1'b0;
        break;
      end
    end
    send_tx = 1'b0;
    check("refill_wait", waited, 26);
    wait_idle(1200, "burst_idle_timeout");
    check("burst_accepted", m_accepted - acc0, 18);
    check("burst_done_cnt", done_cnt - d0, 18);
    exp_q.delete();
    for (int i = 1; i <= 17; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h7E);
    check("burst_rx_n", rxq.size(), 18);
    for (int i = 0; i < 18; i++)
      if (i < rxq.size()) check("burst_rx", rxq[i], exp_q[i]);

    // 0x00 gives a 36-cycle low run, 0xFF only the start bit.
    rxq.delete();
    runs.delete();
    write_byte(8'h00);
    write_byte(8'hFF);
    wait_idle(200, "edge_idle_timeout");
    check("edge_runs_n", runs.size(), 2);
    if (runs.size() == 2) begin
      check("run_00", runs[0], 9 * CPB);
      check("run_ff", runs[1], CPB);
    end
    check("edge_rx_n", rxq.size(), 2);
    if (rxq.size() == 2) begin
      check("edge_rx0", rxq[0], 8'h00);
      check("edge_rx1", rxq[1], 8'hFF);
    end

    // Reset in the middle of bit 0 of 0x3C with more bytes queued.
    rxq.delete();
    @(posedge clk); #1;
    data_tx = 8'h3C;
    send_tx = 1'b1;
    @(posedge clk); #1;
    data_tx = 8'h55;
    @(posedge clk); #1;
    data_tx = 8'h66;
    @(posedge clk); #1;
    send_tx = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_tx_low", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("async_tx_high", tx, 1'b1);
    check("async_busy", busy_tx, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("post_rst_ready", ready_tx, 1'b1);
    check("post_rst_busy", busy_tx, 1'b0);
    check("post_rst_rx", rxq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
